// File: rtl/ppm_pkg.sv
// Shared types and helpers for the PPM pulser.
//   state_e   : frame sequencer state
//   frame_len : frame length in cycles, ((2^sym_w) + guard_slots) * slot_cyc
package ppm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

  function automatic int unsigned frame_len(input int unsigned sym_w,
                                            input int unsigned slot_cyc,
                                            input int unsigned guard_slots);
    return ((32'd1 << sym_w) + guard_slots) * slot_cyc;
  endfunction

endpackage

// File: rtl/ppm_pulser_counter.sv
// Wrapping up-counter 0..MAX with synchronous clear and enable.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : load zero (wins over en)
//   en         : advance by one, wrapping MAX -> 0
//   count_q    : registered count
//   count_d_c  : next count (combinational)
//   wrap_c     : count is at MAX and advancing this cycle (combinational)
module ppm_pulser_counter #(
  parameter int unsigned MAX = 1,
  localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count_q,
  output logic [W-1:0] count_d_c,
  output logic         wrap_c
);

  logic [W-1:0] count_d;
  logic         at_max;

  // Next-count selection
  always_comb begin
    at_max  = (count_q == W'(MAX));
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  assign count_d_c = count_d;
  assign wrap_c    = en && !clr && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ppm_pulser.sv
// Pulse-position modulator: each accepted symbol produces one frame of
// 2^SYM_W data slots plus GUARD_SLOTS idle slots; a pulse of PULSE_CYC
// cycles starts at the beginning of slot number sym.
//   clk, rst    : clock, asynchronous active-high reset
//   sym_data    : symbol to transmit, captured on accept
//   sym_valid   : sym_data valid
//   sym_ready   : symbol can be accepted this cycle (idle or last frame cycle)
//   pulse       : PPM output
//   busy        : frame in progress
//   frame_done  : strobe in the last cycle of a frame
module ppm_pulser
  import ppm_pkg::*;
#(
  parameter int unsigned SYM_W       = 4,
  parameter int unsigned SLOT_CYC    = 50,
  parameter int unsigned PULSE_CYC   = 50,
  parameter int unsigned GUARD_SLOTS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_data,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             pulse,
  output logic             busy,
  output logic             frame_done
);

  // Slots per frame is the frame length measured with one-cycle slots
  localparam int unsigned NUM_SLOTS = frame_len(SYM_W, 1, GUARD_SLOTS);
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);
  localparam int unsigned CYC_MAX   = SLOT_CYC - 1;
  localparam int unsigned CYC_W     = (CYC_MAX > 0) ? $clog2(CYC_MAX + 1) : 1;

  if (SYM_W < 1 || SLOT_CYC < 1 || PULSE_CYC < 1 || PULSE_CYC > SLOT_CYC) begin : g_param_check
    $error("ppm_pulser: illegal SYM_W/SLOT_CYC/PULSE_CYC combination");
  end

  state_e            state_q, state_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              cyc_wrap, cnt_clr, cnt_en;
  logic              accept, last_cyc;
  logic              pulse_q, pulse_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              sym_ready_q, sym_ready_d;

  assign accept   = sym_valid && sym_ready_q;
  assign last_cyc = (state_q == ST_FRAME) && (slot_q == SLOT_W'(NUM_SLOTS - 1))
                    && (cyc_q == CYC_W'(CYC_MAX));
  // Counters restart on every frame start and return to zero when a frame ends
  assign cnt_clr  = accept || last_cyc;
  assign cnt_en   = (state_q == ST_FRAME);

  ppm_pulser_counter #(
    .MAX(CYC_MAX)
  ) u_cyc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .count_q  (cyc_q),
    .count_d_c(cyc_d),
    .wrap_c   (cyc_wrap)
  );

  // Next state, slot count and outputs; outputs are derived from the next
  // position so the registered values line up with the frame cycle they describe
  always_comb begin
    state_d      = state_q;
    sym_d        = sym_q;
    slot_d       = slot_q;
    pulse_d      = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    sym_ready_d  = 1'b0;

    if (accept) begin
      state_d = ST_FRAME;
      sym_d   = sym_data;
      slot_d  = '0;
    end else if (last_cyc) begin
      state_d = ST_IDLE;
      slot_d  = '0;
    end else if (cyc_wrap) begin
      slot_d = slot_q + SLOT_W'(1);
    end

    if (state_d == ST_FRAME) begin
      busy_d       = 1'b1;
      pulse_d      = (slot_d == SLOT_W'(sym_d)) && (32'(cyc_d) < PULSE_CYC);
      frame_done_d = (slot_d == SLOT_W'(NUM_SLOTS - 1)) && (cyc_d == CYC_W'(CYC_MAX));
    end
    sym_ready_d = (state_d == ST_IDLE) || frame_done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sym_q        <= '0;
      slot_q       <= '0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sym_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_q        <= sym_d;
      slot_q       <= slot_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      sym_ready_q  <= sym_ready_d;
    end
  end

  assign sym_ready  = sym_ready_q;
  assign pulse      = pulse_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
